// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory port and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, pc_out, pc_plus4_out, inst_out, valid_out, fetch_err, fetch_cnt
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, pc_out, pc_plus4_out, inst_out, valid_out, fetch_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, zero-latency instruction memory lookup and
// the IF/ID pipeline register, with redirect/flush, stall hold and sticky fetch errors.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_EMPTY = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        in_range;

  // Words past the end of memory must not alias back into it via imem_addr.
  assign in_range = (pc_q[31:2] < IMEM_LIMIT);

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first, so no
    // path through the branches below can leave one unassigned and infer a latch.
    pc_d   = pc_q;
    ifid_d = ifid_q;
    err_d  = err_q;
    cnt_d  = cnt_q;

    if (bus.redirect_valid) begin
      pc_d   = {bus.redirect_target[31:2], 2'b00};
      ifid_d = IFID_EMPTY;
      if (bus.redirect_target[1:0] != 2'b00) err_d = 1'b1;
    end else if (!bus.stall) begin
      pc_d = pc_q + 32'd4;
      if (in_range) begin
        ifid_d = '{pc: pc_q, inst: bus.imem_data, valid: 1'b1};
        cnt_d  = cnt_q + 32'd1;
      end else begin
        ifid_d = '{pc: pc_q, inst: NOP_INST, valid: 1'b0};
        err_d  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= IFID_EMPTY;
      err_q  <= 1'b0;
      cnt_q  <= 32'h0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q[7:2];
  assign bus.pc_out       = ifid_q.pc;
  assign bus.pc_plus4_out = ifid_q.pc + 32'd4;
  assign bus.inst_out     = ifid_q.inst;
  assign bus.valid_out    = ifid_q.valid;
  assign bus.fetch_err    = err_q;
  assign bus.fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle corner
// sequences and a randomized run against an architectural reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  fetch_unit_if ifc ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .NOP_INST   (NOP),
    .IMEM_WORDS (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  logic [31:0] mem [64];
  assign ifc.imem_data = mem[ifc.imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Architectural reference: program counter, IF/ID slot, error flag, fetch count.
  logic [31:0] m_pc, m_pc_out, m_inst, m_cnt;
  logic        m_valid, m_err;

  task automatic model_reset();
    m_pc = 32'h0; m_pc_out = 32'h0; m_inst = NOP; m_valid = 1'b0;
    m_err = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic stall, input logic rv, input logic [31:0] tgt);
    if (rv) begin
      if (tgt % 4 != 0) m_err = 1'b1;
      m_pc = tgt - (tgt % 4);
      m_pc_out = 32'h0; m_inst = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_pc_out = m_pc;
      if (m_pc / 4 < 64) begin
        m_inst = mem[m_pc / 4]; m_valid = 1'b1; m_cnt = m_cnt + 1;
      end else begin
        m_inst = NOP; m_valid = 1'b0; m_err = 1'b1;
      end
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " imem_addr"}, 32'(ifc.imem_addr), (m_pc / 4) % 64);
    check({tag, " pc_out"},    ifc.pc_out,         m_pc_out);
    check({tag, " pc_plus4"},  ifc.pc_plus4_out,   m_pc_out + 4);
    check({tag, " inst_out"},  ifc.inst_out,       m_inst);
    check({tag, " valid_out"}, 32'(ifc.valid_out), 32'(m_valid));
    check({tag, " fetch_err"}, 32'(ifc.fetch_err), 32'(m_err));
    check({tag, " fetch_cnt"}, ifc.fetch_cnt,      m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ifc.stall = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all("reset");
    rst = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] pc_out;
    logic [31:0] inst;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
    logic [5:0]  addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // stall rv target      pc_out        inst           v     err   cnt    addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h0,  32'h0000_2083, 1'b1, 1'b0, 32'd1, 6'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h4,  32'h0040_2103, 1'b1, 1'b0, 32'd2, 6'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  32'h4,  32'h0040_2103, 1'b1, 1'b0, 32'd2, 6'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h4,  32'h0040_2103, 1'b1, 1'b0, 32'd2, 6'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  32'h4,  32'h0040_2103, 1'b1, 1'b0, 32'd2, 6'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'h8,  32'hA000_0002, 1'b1, 1'b0, 32'd3, 6'd3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  32'hC,  32'hA000_0003, 1'b1, 1'b0, 32'd4, 6'd4};
    vecs[7]  = '{1'b1, 1'b1, 32'h10, 32'h0,  NOP,           1'b0, 1'b0, 32'd4, 6'd4};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  32'h10, 32'hA000_0004, 1'b1, 1'b0, 32'd5, 6'd5};
    vecs[9]  = '{1'b0, 1'b1, 32'hA,  32'h0,  NOP,           1'b0, 1'b1, 32'd5, 6'd2};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  32'h8,  32'hA000_0002, 1'b1, 1'b1, 32'd6, 6'd3};

    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0040_2103;
    for (int i = 2; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);

    // Reset state and directed vector table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      ifc.stall = vecs[i].stall;
      ifc.redirect_valid = vecs[i].rv;
      ifc.redirect_target = vecs[i].tgt;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d pc_out", i),    ifc.pc_out,         vecs[i].pc_out);
      check($sformatf("vec%0d pc_plus4", i),  ifc.pc_plus4_out,   vecs[i].pc_out + 32'd4);
      check($sformatf("vec%0d inst_out", i),  ifc.inst_out,       vecs[i].inst);
      check($sformatf("vec%0d valid_out", i), 32'(ifc.valid_out), 32'(vecs[i].valid));
      check($sformatf("vec%0d fetch_err", i), 32'(ifc.fetch_err), 32'(vecs[i].err));
      check($sformatf("vec%0d fetch_cnt", i), ifc.fetch_cnt,      vecs[i].cnt);
      check($sformatf("vec%0d imem_addr", i), 32'(ifc.imem_addr), 32'(vecs[i].addr));
    end

    // Sticky error survives ten further plain fetches.
    ifc.stall = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_target = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sticky%0d fetch_err", i), 32'(ifc.fetch_err), 32'd1);
    end

    // Run off the end of memory: 64 good fetches, then an out-of-range one.
    do_reset();
    repeat (64) @(posedge clk);
    @(negedge clk);
    check("end64 fetch_cnt", ifc.fetch_cnt, 32'd64);
    check("end64 fetch_err", 32'(ifc.fetch_err), 32'd0);
    check("end64 pc_out",    ifc.pc_out, 32'd252);
    check("end64 inst_out",  ifc.inst_out, 32'hA000_003F);
    @(posedge clk);
    @(negedge clk);
    check("oor valid_out", 32'(ifc.valid_out), 32'd0);
    check("oor inst_out",  ifc.inst_out, NOP);
    check("oor fetch_err", 32'(ifc.fetch_err), 32'd1);
    check("oor fetch_cnt", ifc.fetch_cnt, 32'd64);
    check("oor imem_addr", 32'(ifc.imem_addr), 32'd1);

    // Short asynchronous reset pulse in the middle of a stall.
    ifc.stall = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst pc_out",    ifc.pc_out, 32'h0);
    check("arst inst_out",  ifc.inst_out, NOP);
    check("arst valid_out", 32'(ifc.valid_out), 32'd0);
    check("arst fetch_err", 32'(ifc.fetch_err), 32'd0);
    check("arst fetch_cnt", ifc.fetch_cnt, 32'd0);
    check("arst imem_addr", 32'(ifc.imem_addr), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    ifc.stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("restart pc_out",    ifc.pc_out, 32'h0);
    check("restart inst_out",  ifc.inst_out, 32'h0000_2083);
    check("restart valid_out", 32'(ifc.valid_out), 32'd1);
    check("restart fetch_cnt", ifc.fetch_cnt, 32'd1);

    // Randomized runs against the reference model: aligned in-range redirects first,
    // then arbitrary targets (misaligned, out of range, near the 2^32 wrap).
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        logic        s, r;
        logic [31:0] t;
        s = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 9) == 0);
        if (seg == 0)                          t = 32'($urandom_range(0, 63)) * 4;
        else if ($urandom_range(0, 4) == 0)    t = $urandom;
        else                                   t = 32'($urandom_range(0, 300));
        ifc.stall = s; ifc.redirect_valid = r; ifc.redirect_target = t;
        @(posedge clk);
        model_step(s, r, t);
        @(negedge clk);
        compare_all($sformatf("rand%0d.%0d", seg, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
